// File: rtl/kgp_pkg.sv
// Shared definitions for the instruction sequencer.
// Holds the opcode constants, the sequencer state encoding and small
// instruction-classification helpers. Both the sequencer FSM and the
// decode logic import this package so they agree on every encoding.
package kgp_pkg;

    localparam logic [4:0] OP_R    = 5'd0;
    localparam logic [4:0] OP_I    = 5'd1;
    localparam logic [4:0] OP_LS   = 5'd2;
    localparam logic [4:0] OP_BR1  = 5'd3;
    localparam logic [4:0] OP_BR2  = 5'd4;
    localparam logic [4:0] OP_BR3  = 5'd5;
    localparam logic [4:0] OP_HALT = 5'b11111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Branch-and-link: BR2 with funccode[2:0] = 001. Its PC is written in
    // EXEC, so the following WB must only write the register file.
    function automatic logic is_link(input logic [4:0] op, input logic [4:0] fc);
        return (op == OP_BR2) && (fc[2:0] == 3'b001);
    endfunction

    function automatic logic is_branch(input logic [4:0] op);
        return (op >= OP_BR1) && (op <= OP_BR3);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory-wait watchdog for the instruction sequencer.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restart the count (no access pending, or access completing)
//   count     - a request is outstanding without acknowledge this cycle
//   expired   - this un-acknowledged cycle is the TIMEOUT-th one
// expired is combinational on count so the FSM can leave for HALT on the
// very edge that ends the TIMEOUT-th wait cycle; the FSM gives mem_ack
// priority, so an ack arriving in that same cycle still completes.
module wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);
    localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_reg;

    assign expired = count && (cnt_reg == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (count && !expired) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer for a shared-memory CPU.
// Walks IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH and
// generates the datapath strobes for each step.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start               - leave IDLE and begin fetching
//   opcode, funccode    - fields of the latched instruction register
//   br_taken            - branch condition, sampled in EXEC
//   mem_ack             - shared memory completed the current request
//   mem_req/we/sel      - memory request, write enable, owner (0 fetch, 1 data)
//   ir_write, pc_write  - IR load, PC load
//   pc_src              - PC source (0 PC+4, 1 branch target)
//   reg_write           - register file write
//   halted, fault       - sequencer stopped; stop caused by an error
//   retired             - count of PC updates (completed instructions)
module instr_sequencer
    import kgp_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic [4:0]       funccode,
    input  logic             br_taken,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    state_t           state_reg, state_next;
    logic             fault_reg, fault_next;
    logic [CNT_W-1:0] retired_reg;
    logic             wait_expired;

    // Every completed access (or any cycle without a request) restarts the
    // timer, which covers the direct MEM -> FETCH hop after a store.
    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!mem_req || mem_ack),
        .count   (mem_req && !mem_ack),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            fault_reg   <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            fault_reg <= fault_next;
            if (pc_write) begin
                retired_reg <= retired_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        fault_next = fault_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_sel    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        halted     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_FETCH;
                end
            end

            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_write   = 1'b1;
                    state_next = ST_DECODE;
                end else if (wait_expired) begin
                    state_next = ST_HALT;
                    fault_next = 1'b1;
                end
            end

            ST_DECODE: begin
                if (opcode <= OP_BR3) begin
                    state_next = ST_EXEC;
                end else begin
                    state_next = ST_HALT;
                    fault_next = (opcode != OP_HALT);
                end
            end

            ST_EXEC: begin
                if (opcode == OP_R || opcode == OP_I) begin
                    state_next = ST_WB;
                end else if (opcode == OP_LS) begin
                    state_next = ST_MEM;
                end else if (is_branch(opcode)) begin
                    pc_write   = 1'b1;
                    pc_src     = br_taken;
                    state_next = is_link(opcode, funccode) ? ST_WB : ST_FETCH;
                end else begin
                    // Unreachable through DECODE; treated as an illegal opcode.
                    state_next = ST_HALT;
                    fault_next = 1'b1;
                end
            end

            ST_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = funccode[0];
                if (mem_ack) begin
                    if (funccode[0]) begin
                        pc_write   = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WB;
                    end
                end else if (wait_expired) begin
                    state_next = ST_HALT;
                    fault_next = 1'b1;
                end
            end

            ST_WB: begin
                reg_write  = 1'b1;
                pc_write   = !is_link(opcode, funccode);
                state_next = ST_FETCH;
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign fault   = fault_reg;
    assign retired = retired_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer. Per-instruction tasks expand each
// instruction into the cycle-by-cycle output vectors the rules demand, and a
// single compare process checks the DUT against them on every falling edge.
module tb_instr_sequencer;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 16;

    logic clk = 1'b0;
    logic rst, start, br_taken, mem_ack;
    logic [4:0] opcode, funccode;
    logic mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, reg_write;
    logic halted, fault;
    logic [CNT_W-1:0] retired;

    always #5 clk = ~clk;

    instr_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funccode(funccode),
        .br_taken(br_taken), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .mem_sel(mem_sel), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .halted(halted), .fault(fault), .retired(retired)
    );

    // Output vector: {req, we, sel, ir_write, pc_write, pc_src, reg_write, halted, fault}
    logic [8:0] act_vec;
    assign act_vec = {mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, reg_write, halted, fault};

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0]       exp_vec;
    logic [CNT_W-1:0] exp_ret;
    bit               exp_valid = 1'b0;
    string            exp_tag;
    logic [CNT_W-1:0] model_ret;

    function automatic logic [8:0] mk(input logic req, input logic we, input logic sel,
                                      input logic irw, input logic pcw, input logic pcs,
                                      input logic rw, input logic h, input logic f);
        return {req, we, sel, irw, pcw, pcs, rw, h, f};
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            n_tests++;
            if (act_vec !== exp_vec || retired !== exp_ret) begin
                n_fail++;
                $display("FAIL %s: got vec=%b retired=%0d, expected vec=%b retired=%0d",
                         exp_tag, act_vec, retired, exp_vec, exp_ret);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, publish the expectation, advance.
    task automatic cyc(input logic [8:0] v, input logic ack, input logic brt,
                       input logic st, input string tag);
        mem_ack   = ack;
        br_taken  = brt;
        start     = st;
        exp_vec   = v;
        exp_ret   = model_ret;
        exp_tag   = tag;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
        if (v[4]) model_ret = model_ret + 1'b1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Runs one instruction starting in FETCH. fw/mw: cycles without ack
    // before the ack (>= TIMEOUT means never acked). abort_mem > 0 returns
    // mid-MEM after that many wait cycles.
    task automatic run_instr(input logic [4:0] op, input logic [4:0] fc, input int fw,
                             input int mw, input logic brt, input int abort_mem,
                             output bit h_o, output bit f_o);
        bit br, link, we;
        h_o = 0;
        f_o = 0;
        opcode   = op;
        funccode = fc;
        for (int i = 0; i < fw && i < TIMEOUT; i++)
            cyc(mk(1,0,0,0,0,0,0,0,0), 1'b0, rb(), 1'b0, "fetch_wait");
        if (fw >= TIMEOUT) begin h_o = 1; f_o = 1; return; end
        cyc(mk(1,0,0,1,0,0,0,0,0), 1'b1, rb(), 1'b0, "fetch_ack");
        cyc(mk(0,0,0,0,0,0,0,0,0), rb(), rb(), rb(), "decode");
        if (op == 5'd31) begin h_o = 1; f_o = 0; return; end
        if (op > 5'd5)   begin h_o = 1; f_o = 1; return; end
        br   = (op >= 5'd3 && op <= 5'd5);
        link = (op == 5'd4 && fc[2:0] == 3'b001);
        cyc(mk(0,0,0,0,br,br & brt,0,0,0), rb(), brt, 1'b0, "exec");
        if (br && !link) return;
        if (op == 5'd2) begin
            we = fc[0];
            for (int i = 0; i < mw && i < TIMEOUT; i++) begin
                if (abort_mem > 0 && i == abort_mem) return;
                cyc(mk(1,we,1,0,0,0,0,0,0), 1'b0, rb(), 1'b0, "mem_wait");
            end
            if (mw >= TIMEOUT) begin h_o = 1; f_o = 1; return; end
            cyc(mk(1,we,1,0,we,0,0,0,0), 1'b1, rb(), 1'b0, "mem_ack");
            if (we) return;
        end
        cyc(mk(0,0,0,0,!link,0,1,0,0), rb(), rb(), 1'b0, "wb");
    endtask

    task automatic halt_phase(input bit f);
        for (int i = 0; i < 3; i++)
            cyc(mk(0,0,0,0,0,0,0,1,f), rb(), rb(), rb(), "halt");
    endtask

    // Asynchronous reset mid-cycle, then stray acks in IDLE, then start.
    task automatic do_reset();
        exp_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_outputs_async", int'(act_vec), 0);
        check("rst_retired", int'(retired), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_ret = '0;
        cyc(mk(0,0,0,0,0,0,0,0,0), 1'b1, rb(), 1'b0, "idle_stray_ack");
        cyc(mk(0,0,0,0,0,0,0,0,0), 1'b1, rb(), 1'b0, "idle_stray_ack");
        cyc(mk(0,0,0,0,0,0,0,0,0), rb(), rb(), 1'b1, "idle_start");
    endtask

    task automatic do_instr(input int idx, input logic [4:0] op, input logic [4:0] fc,
                            input int fw, input int mw, input logic brt);
        bit h, f;
        run_instr(op, fc, fw, mw, brt, 0, h, f);
        $display("[TB] instr %0d op=%0d fc=%b fw=%0d mw=%0d br=%0d -> %s fault=%0d retired=%0d",
                 idx, op, fc, fw, mw, brt, h ? "halt" : "done", f, model_ret);
        if (h) begin
            halt_phase(f);
            do_reset();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h, f;
        int r, fw, mw;
        logic [4:0] op;
        rst = 1'b1; start = 0; br_taken = 0; mem_ack = 0; opcode = 0; funccode = 0;
        model_ret = '0;
        @(posedge clk); @(posedge clk); #1;
        check("reset_outputs", int'(act_vec), 0);
        check("reset_retired", int'(retired), 0);
        rst = 1'b0;
        cyc(mk(0,0,0,0,0,0,0,0,0), 1'b1, 1'b0, 1'b0, "idle_no_start");
        cyc(mk(0,0,0,0,0,0,0,0,0), 1'b0, 1'b0, 1'b1, "idle_start");

        // Directed cases with literal pins on the retired count.
        do_instr(0, 5'd0, 5'd0, 0, 0, 1'b0);                  // R-type, 0-cycle ack
        check("pin_r_retired", int'(retired), 1);
        do_instr(1, 5'd2, 5'd0, 1, 2, 1'b0);                  // load, data held 3 cycles
        check("pin_load_retired", int'(retired), 2);
        do_instr(2, 5'd2, 5'd1, 0, 1, 1'b0);                  // store
        check("pin_store_retired", int'(retired), 3);
        do_instr(3, 5'd4, 5'b00001, 0, 0, 1'b1);              // branch-and-link taken
        check("pin_link_retired", int'(retired), 4);
        do_instr(4, 5'd1, 5'd0, TIMEOUT - 1, 0, 1'b0);        // fetch ack at cycle 15
        check("pin_ack15_retired", int'(retired), 5);
        do_instr(5, 5'd2, 5'd0, 0, TIMEOUT - 1, 1'b0);        // data ack at cycle 15
        check("pin_mem_ack15_retired", int'(retired), 6);

        // Reset in the middle of a data access.
        run_instr(5'd2, 5'd0, 0, 5, 1'b0, 2, h, f);
        $display("[TB] instr 6 load aborted by reset mid-MEM");
        do_reset();
        check("pin_after_reset_retired", int'(retired), 0);

        do_instr(7, 5'd0, 5'd0, TIMEOUT, 0, 1'b0);            // fetch timeout
        do_instr(8, 5'b01010, 5'd0, 0, 0, 1'b0);              // illegal opcode
        do_instr(9, 5'b11111, 5'd0, 0, 0, 1'b0);              // clean halt
        do_instr(10, 5'd2, 5'd1, 0, TIMEOUT, 1'b0);           // data timeout
        do_instr(11, 5'd3, 5'd0, 2, 0, 1'b1);                 // BR1 taken
        do_instr(12, 5'd5, 5'd0, 0, 0, 1'b0);                 // BR3 not taken

        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 99);
            if (r < 86)      op = 5'($urandom_range(0, 5));
            else if (r < 93) op = 5'd31;
            else             op = 5'($urandom_range(6, 30));
            r  = $urandom_range(0, 99);
            fw = (r < 85) ? $urandom_range(0, 3) : (r < 95) ? TIMEOUT - 1 : TIMEOUT;
            r  = $urandom_range(0, 99);
            mw = (r < 85) ? $urandom_range(0, 3) : (r < 95) ? TIMEOUT - 1 : TIMEOUT;
            do_instr(100 + k, op, 5'($urandom), fw, mw, rb());
        end

        exp_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: max cycles to wait for mem_ack before a fault.
REQ-002 SHALL have parameter CNT_W, default 16: width of retired-instruction counter.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: leave IDLE and begin fetching.
REQ-006 SHALL have ports opcode, funccode, input, 5 each: fields of the latched instruction register.
REQ-007 SHALL have port br_taken, input, 1: branch condition from the datapath, valid in EXEC.
REQ-008 SHALL have port mem_ack, input, 1: shared memory completed the current request.
REQ-009 SHALL have ports mem_req, mem_we, mem_sel, output, 1 each: memory request, write enable, port owner (0 = instruction fetch, 1 = data).
REQ-010 SHALL have ports ir_write, pc_write, pc_src, reg_write, output, 1 each: IR load, PC load, PC source (0 = PC+4, 1 = branch target), register file write.
REQ-011 SHALL have ports halted, fault, output, 1 each: sequencer stopped; stop caused by an error.
REQ-012 SHALL have port retired, output, CNT_W: count of completed instructions.

Function
REQ-013 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-014 IDLE SHALL go to FETCH on start=1, otherwise stay; all strobes 0.
REQ-015 FETCH SHALL drive mem_req=1, mem_sel=0, mem_we=0 until mem_ack; in the ack cycle it SHALL pulse ir_write=1 and move to DECODE.
REQ-016 DECODE SHALL last exactly 1 cycle: opcode 0-5 go to EXEC, 5'b11111 goes to HALT with fault=0, and any other value goes to HALT with fault=1.
REQ-017 EXEC SHALL last exactly 1 cycle: opcode R (0) or I (1) goes to WB, and LS (2) goes to MEM.
REQ-018 EXEC on BR1/BR2/BR3 (3-5) SHALL pulse pc_write=1 with pc_src=br_taken.
REQ-019 After a branch EXEC, the next state SHALL be WB when opcode=BR2 and funccode[2:0]=001 (link); otherwise FETCH.
REQ-020 MEM SHALL drive mem_req=1, mem_sel=1, mem_we=funccode[0] until mem_ack.
REQ-021 On mem_ack in MEM, a store SHALL pulse pc_write=1 with pc_src=0 and go to FETCH; a load SHALL go to WB.
REQ-022 WB SHALL pulse reg_write=1 for 1 cycle, then go to FETCH.
REQ-023 WB SHALL pulse pc_write=1 with pc_src=0 except for a link instruction, whose PC was already written in EXEC.
REQ-024 retired SHALL increment by 1, wrapping modulo 2^CNT_W, in every cycle where pc_write=1.
REQ-025 A wait counter SHALL clear on entry to FETCH or MEM and count each cycle mem_req=1 without mem_ack.
REQ-026 When the wait counter reaches TIMEOUT with no ack, the sequencer SHALL go to HALT with fault=1 on the next edge and drop mem_req.
REQ-027 mem_ack arriving in the same cycle as the TIMEOUT threshold SHALL win; the access completes normally.
REQ-028 mem_ack outside FETCH/MEM SHALL be ignored.
REQ-029 HALT SHALL be absorbing: halted=1, all strobes 0, fault held; only rst exits.
REQ-030 All strobes SHALL be Moore/Mealy decodes of the current state and inputs with no extra cycle of latency, and at most one of ir_write, pc_write+reg_write-in-EXEC conflicts SHALL occur (ir_write never coincides with pc_write or reg_write).

Reset
REQ-031 On rst=1, the sequencer SHALL immediately enter IDLE, even mid-access.
REQ-032 On rst=1, retired, the wait counter, fault and halted SHALL clear to 0, and all outputs SHALL be 0.
REQ-033 An outstanding memory request SHALL be abandoned on reset; a later stray mem_ack in IDLE SHALL be ignored.

Structure
REQ-034 Opcode constants (R, I, LS, BR1, BR2, BR3, HALT=5'b11111) and the state encoding SHALL live in shared package kgp_pkg, reused by the decoder.
REQ-035 The wait/timeout counter SHALL be a sub-module named wait_timer (inputs clear, count; output expired).

Verification
REQ-036 Directed test: start, R-type fetched with 0-cycle ack -> sequence FETCH, DECODE, EXEC, WB, FETCH; one reg_write pulse; retired=1.
REQ-037 Directed test: load (opcode 2, funccode 0) with 3-cycle data ack -> mem_req,sel=1,we=0 held 3 cycles, then WB reg_write; store (funccode 1) -> mem_we=1, no reg_write, pc_write on ack.
REQ-038 Directed test: BR2 funccode 001 with br_taken=1 -> pc_write, pc_src=1 in EXEC, reg_write in WB, and no second pc_write.
REQ-039 Directed test: fetch ack withheld -> HALT with fault=1 after TIMEOUT=15 wait cycles; with ack exactly at cycle 15 -> completes normally.
REQ-040 Directed test: opcode 5'b01010 -> HALT fault=1; opcode 5'b11111 -> HALT fault=0; both stay halted.
REQ-041 Directed test: rst asserted mid-MEM -> outputs 0 asynchronously, IDLE, retired=0; a following stray mem_ack produces no effect.
